// File: rtl/mod_n_updown_counter_pkg.sv
// Shared constants and elaboration helpers for the modulo-N up/down counter.
// Optional saturate mode is selected with MOD_N_UPDOWN_SATURATE_EN (see mod_n_step).
package mod_n_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // True when the modulus fits the count width: 2 <= n <= 2**width.
    function automatic bit param_ok(input int n, input int width);
        bit ok;
        ok = 1'b0;
        if ((width >= 32'sd1) && (width <= 32'sd30) && (n >= 32'sd2)) begin
            ok = (longint'(n) <= (64'sd1 <<< width));
        end else begin
            ok = 1'b0;
        end
        return ok;
    endfunction

    // Even parity of a count value, for downstream integrity checks.
    function automatic logic count_parity(input logic [31:0] value);
        return ^value;
    endfunction

endpackage

// File: rtl/mod_n_updown_counter_if.sv
// Control/status bundle of the modulo-N counter: the driver side is master,
// the counter itself is slave.
interface mod_n_updown_counter_if #(
    parameter int WIDTH = 4
) ();

    logic             en;
    logic             dir;
    logic             load;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             ovf;

    modport master (
        output en,
        output dir,
        output load,
        output din,
        input  q,
        input  tc,
        input  ovf
    );

    modport slave (
        input  en,
        input  dir,
        input  load,
        input  din,
        output q,
        output tc,
        output ovf
    );

endinterface

// File: rtl/mod_n_updown_counter_step.sv
// Combinational next-count logic of the modulo-N counter. Wraps at the bounds
// by default; with MOD_N_UPDOWN_SATURATE_EN defined it holds at the bounds.
module mod_n_step
    import mod_n_pkg::*;
#(
    parameter int N     = 10,
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] q,
    input  logic             dir,
    input  logic             en,
    output logic [WIDTH-1:0] next_q,
    output logic             limit
);

    // One extra bit keeps q+1 exact when N = 2**WIDTH.
    localparam logic [WIDTH:0] TOP_C  = (WIDTH+1)'(N - 1);
    localparam logic [WIDTH:0] ONE_C  = (WIDTH+1)'(1);
    localparam logic [WIDTH:0] ZERO_C = (WIDTH+1)'(0);

    logic [WIDTH:0] q_ext_s;
    logic [WIDTH:0] inc_s;
    logic [WIDTH:0] dec_s;
    logic [WIDTH:0] next_ext_s;
    logic           limit_s;
    logic           unused_s;

    assign q_ext_s = {1'b0, q};
    assign inc_s   = q_ext_s + ONE_C;
    assign dec_s   = q_ext_s - ONE_C;

    // Select the next count and flag any attempt to pass a bound.
    always_comb begin
        next_ext_s = q_ext_s;
        limit_s    = 1'b0;
        if (!en) begin
            next_ext_s = q_ext_s;
            limit_s    = 1'b0;
        end else if (q_ext_s > TOP_C) begin
            // Corrupted state: recover to zero whichever way we step.
            next_ext_s = ZERO_C;
            limit_s    = 1'b1;
        end else if (dir == DIR_UP) begin
            if (q_ext_s == TOP_C) begin
`ifdef MOD_N_UPDOWN_SATURATE_EN
                next_ext_s = TOP_C;
`else
                next_ext_s = ZERO_C;
`endif
                limit_s    = 1'b1;
            end else begin
                next_ext_s = inc_s;
                limit_s    = 1'b0;
            end
        end else begin
            if (q_ext_s == ZERO_C) begin
`ifdef MOD_N_UPDOWN_SATURATE_EN
                next_ext_s = ZERO_C;
`else
                next_ext_s = TOP_C;
`endif
                limit_s    = 1'b1;
            end else begin
                next_ext_s = dec_s;
                limit_s    = 1'b0;
            end
        end
    end

    assign next_q   = next_ext_s[WIDTH-1:0];
    assign limit    = limit_s;
    assign unused_s = ^{inc_s[WIDTH], dec_s[WIDTH], next_ext_s[WIDTH]};

endmodule

// File: rtl/mod_n_updown_counter.sv
// Loadable modulo-N up/down counter with combinational cascade output tc and
// registered wrap pulse ovf. Build macro: MOD_N_UPDOWN_SATURATE_EN (saturate mode).
module mod_n_updown_counter
    import mod_n_pkg::*;
#(
    parameter int N     = 10,
    parameter int WIDTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    mod_n_updown_counter_if.slave       bus
);

    if (!param_ok(N, WIDTH)) begin : g_param_err
        $error("mod_n_updown_counter: N=%0d outside 2..2**WIDTH (WIDTH=%0d)", N, WIDTH);
    end

    localparam logic [WIDTH:0]   TOP_EXT_C = (WIDTH+1)'(N - 1);
    localparam logic [WIDTH-1:0] TOP_C     = TOP_EXT_C[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ZERO_C    = WIDTH'(0);

    logic [WIDTH-1:0] q_r;
    logic             ovf_r;
    logic [WIDTH-1:0] step_q_s;
    logic             step_limit_s;
    logic [WIDTH-1:0] load_q_s;
    logic             tc_s;

    mod_n_step #(
        .N     (N),
        .WIDTH (WIDTH)
    ) u_step (
        .q      (q_r),
        .dir    (bus.dir),
        .en     (bus.en),
        .next_q (step_q_s),
        .limit  (step_limit_s)
    );

    // Clamp loaded values above N-1 to N-1 so q never leaves 0..N-1.
    always_comb begin
        load_q_s = bus.din;
        if ({1'b0, bus.din} > TOP_EXT_C) begin
            load_q_s = TOP_C;
        end else begin
            load_q_s = bus.din;
        end
    end

    // Cascade enable: high in the cycle before a wrap, suppressed during load.
    always_comb begin
        tc_s = 1'b0;
        if (bus.load || !bus.en) begin
            tc_s = 1'b0;
        end else if (bus.dir == DIR_UP) begin
            tc_s = (q_r == TOP_C);
        end else begin
            tc_s = (q_r == ZERO_C);
        end
    end

    // Count register with priority reset > load > enable > hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_r   <= ZERO_C;
            ovf_r <= 1'b0;
        end else if (bus.load) begin
            q_r   <= load_q_s;
            ovf_r <= 1'b0;
        end else if (bus.en) begin
            q_r   <= step_q_s;
            ovf_r <= step_limit_s;
        end else begin
            q_r   <= q_r;
            ovf_r <= 1'b0;
        end
    end

    assign bus.q   = q_r;
    assign bus.ovf = ovf_r;
    assign bus.tc  = tc_s;

endmodule
